dsm_rate_scheduler: RTL and testbench
=====================================

Name: dsm_rate_scheduler

Overview:
- Rate controller that sits between the sample source and the first-order delta-sigma modulator stage of the MASH DAC.
- Buffers incoming AXI-Stream PCM samples in a small FIFO.
- Issues one modulator update per programmable tick, and holds each sample for a programmable number of ticks (zero-order-hold oversampling).
- Handles priming, underrun (zero injection) and enable/disable sequencing.

Parameters:
- WIDTH, 16, sample width (signed two's complement).
- DIV_W, 8, width of tick_div and hold_len.
- FIFO_DEPTH, 4, input FIFO entries; must be a power of 2, >= 2.
- PRIME_LEVEL, 2, FIFO occupancy required to leave PRIME; 1..FIFO_DEPTH.

Ports:
- aclk  in  1  clock.
- arst_n  in  1  synchronous active-low reset.
- enable  in  1  run request; level sensitive.
- tick_div  in  DIV_W  tick period minus 1, in aclk cycles.
- hold_len  in  DIV_W  ticks per input sample minus 1.
- s_axis_data_tdata  in  WIDTH  signed input sample.
- s_axis_data_tvalid  in  1  input valid.
- s_axis_data_tready  out  1  high when FIFO not full and state != IDLE.
- m_axis_data_tdata  out  WIDTH  signed sample to modulator.
- m_axis_data_tvalid  out  1  modulator update strobe.
- m_axis_data_tready  in  1  modulator accept.
- state  out  2  IDLE=0, PRIME=1, RUN=2.
- underrun  out  1  one-cycle pulse on underrun.
- underrun_count  out  16  see Optional Feature.

Behaviour:
- Reset (arst_n=0 at aclk edge): state=IDLE; FIFO empty; tick/hold counters=0; m_axis_data_tdata=0; m_axis_data_tvalid=0; underrun=0; underrun_count=0.
- Config latch: tick_div and hold_len are registered into tick_div_q/hold_len_q only on the IDLE->PRIME transition. Changes at any other time are ignored.
- Tick counter:
  - Active in PRIME and RUN; runs 0..tick_div_q.
  - tick=1 when count==tick_div_q and no output is pending; count then wraps to 0.
  - tick_div_q=0 gives a tick every cycle.
  - While m_axis_data_tvalid=1 and m_axis_data_tready=0, the counter freezes at its terminal value (backpressure stalls the rate; no ticks are dropped).
- Output handshake:
  - On a tick, m_axis_data_tdata and m_axis_data_tvalid=1 are registered.
  - tvalid stays high until the tready handshake, then drops the next cycle unless a new tick coincides.
  - tdata is stable while tvalid=1 and tready=0.
- IDLE:
  - No tvalid; s_axis_data_tready=0; FIFO flushed.
  - enable=1 -> PRIME, with counters cleared.
- PRIME:
  - Each tick emits sample 0 (modulator keeps running at mid-scale).
  - When FIFO level >= PRIME_LEVEL at a tick, that tick instead pops the FIFO head, emits it, sets hold count=0, and moves to RUN.
- RUN:
  - Each tick emits the current held sample. The hold count increments.
  - When hold count==hold_len_q, the next tick pops a new sample and the hold count resets.
  - If the FIFO is empty on a pop tick: emit 0, pulse underrun for 1 cycle, go to PRIME.
- enable=0 in any state: next cycle enters IDLE, flushes the FIFO, and drops m_axis_data_tvalid immediately (a pending beat is abandoned).
- FIFO:
  - Write when s_axis_data_tvalid && s_axis_data_tready.
  - Simultaneous push and pop when full is allowed only in the sense that tready reflects the pre-pop level; no combinational tready path from the pop.
  - Push and pop on an empty FIFO is not bypassed (an empty-FIFO pop is still an underrun).
- Latency: a sample pushed in cycle N is not popped before cycle N+1.
- Width rule: samples pass through unmodified; no sign extension or scaling.

Optional Feature:
- Macro DSM_SCHED_UNDERRUN_CNT_EN.
- Defined: underrun_count increments on each underrun pulse, saturates at 16'hFFFF, and clears on reset or on the IDLE->PRIME transition.
- Undefined: counter logic is omitted and underrun_count is tied to 0. The underrun pulse is still generated.

Test Plan:
- Reset and enable: arst_n low 2 cycles, then enable=1 with tick_div=3 -> state goes 0->1. tvalid pulses every 4 cycles with tdata=0. s_axis_data_tready=1.
- Priming and hold: tick_div=1, hold_len=2, PRIME_LEVEL=2; push 100, 200, 300 -> output sequence 100,100,100,200,200,200,300..., one beat every 2 cycles, state=2.
- Underrun: as above, stop pushing after 300 -> after the third 300 beat, the next beat is 0, underrun pulses once, state=1. Pushing 2 more samples returns state to 2.
- Backpressure: hold m_axis_data_tready=0 for 5 cycles mid-RUN -> tdata is held, no beat is lost or duplicated, and the cadence resumes after release.
- Full FIFO and disable: push 4 samples with no ticks -> s_axis_data_tready=0. Then enable=0 -> next cycle state=0, tvalid=0, FIFO empty. A config change during RUN has no effect until re-enable.
- Counter (macro on): force 3 underruns -> underrun_count=3. Disable/enable -> count=0. Macro off -> count=0 always.

Source files
------------

// File: rtl/dsm_rate_scheduler.sv
// Tick-paced zero-order-hold scheduler feeding the first-order DSM stage from a small PCM FIFO.
// Define DSM_SCHED_UNDERRUN_CNT_EN to build the saturating underrun counter; otherwise underrun_count is 0.
module dsm_rate_scheduler #(
    parameter int unsigned WIDTH       = 16,
    parameter int unsigned DIV_W       = 8,
    parameter int unsigned FIFO_DEPTH  = 4,
    parameter int unsigned PRIME_LEVEL = 2
) (
    input  logic             aclk,
    input  logic             arst_n,
    input  logic             enable,
    input  logic [DIV_W-1:0] tick_div,
    input  logic [DIV_W-1:0] hold_len,
    input  logic [WIDTH-1:0] s_axis_data_tdata,
    input  logic             s_axis_data_tvalid,
    output logic             s_axis_data_tready,
    output logic [WIDTH-1:0] m_axis_data_tdata,
    output logic             m_axis_data_tvalid,
    input  logic             m_axis_data_tready,
    output logic [1:0]       state,
    output logic             underrun,
    output logic [15:0]      underrun_count
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [CW-1:0] FULL_LVL  = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0] PRIME_LVL = CW'(PRIME_LEVEL);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PRIME = 2'd1,
        ST_RUN   = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [DIV_W-1:0]   tick_div_q, tick_div_d;
    logic [DIV_W-1:0]   hold_len_q, hold_len_d;
    logic [DIV_W-1:0]   cnt_q, cnt_d;
    logic [DIV_W-1:0]   hold_q, hold_d;
    logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]      level_q, level_d;
    logic [WIDTH-1:0]   mem_q [FIFO_DEPTH];
    logic [WIDTH-1:0]   mem_d [FIFO_DEPTH];
    logic [WIDTH-1:0]   tdata_q, tdata_d;
    logic               tvalid_q, tvalid_d;
    logic               underrun_q, underrun_d;
    logic               push, pop, tick, pending;

    // Ready is a function of registered level only, so a same-cycle pop never widens it.
    assign s_axis_data_tready = (state_q != ST_IDLE) && (level_q != FULL_LVL);
    assign m_axis_data_tdata  = tdata_q;
    assign m_axis_data_tvalid = tvalid_q;
    assign state              = state_q;
    assign underrun           = underrun_q;

    always_comb begin
        state_d    = state_q;
        tick_div_d = tick_div_q;
        hold_len_d = hold_len_q;
        cnt_d      = cnt_q;
        hold_d     = hold_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        level_d    = level_q;
        mem_d      = mem_q;
        tdata_d    = tdata_q;
        tvalid_d   = tvalid_q;
        underrun_d = 1'b0;
        pop        = 1'b0;
        tick       = 1'b0;
        push       = s_axis_data_tvalid && s_axis_data_tready;
        pending    = tvalid_q && !m_axis_data_tready;

        if (tvalid_q && m_axis_data_tready) begin
            tvalid_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                tvalid_d = 1'b0;
                wr_ptr_d = '0;
                rd_ptr_d = '0;
                level_d  = '0;
                if (enable) begin
                    state_d    = ST_PRIME;
                    tick_div_d = tick_div;
                    hold_len_d = hold_len;
                    cnt_d      = '0;
                    hold_d     = '0;
                end
            end
            ST_PRIME, ST_RUN: begin
                // Counter parks on its terminal value while a beat is stalled.
                tick = (cnt_q == tick_div_q) && !pending;
                if (tick) begin
                    cnt_d = '0;
                end else if (cnt_q != tick_div_q) begin
                    cnt_d = cnt_q + 1'b1;
                end

                if (tick) begin
                    tvalid_d = 1'b1;
                    if (state_q == ST_PRIME) begin
                        if (level_q >= PRIME_LVL) begin
                            pop     = 1'b1;
                            tdata_d = mem_q[rd_ptr_q];
                            hold_d  = '0;
                            state_d = ST_RUN;
                        end else begin
                            tdata_d = '0;
                        end
                    end else if (hold_q == hold_len_q) begin
                        if (level_q == '0) begin
                            tdata_d    = '0;
                            underrun_d = 1'b1;
                            state_d    = ST_PRIME;
                        end else begin
                            pop     = 1'b1;
                            tdata_d = mem_q[rd_ptr_q];
                            hold_d  = '0;
                        end
                    end else begin
                        hold_d = hold_q + 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (push) begin
            mem_d[wr_ptr_q] = s_axis_data_tdata;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: ;
        endcase

        // Disable wins over everything: abandon any beat and flush.
        if (!enable) begin
            state_d    = ST_IDLE;
            tvalid_d   = 1'b0;
            underrun_d = 1'b0;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            level_d    = '0;
        end
    end

    always_ff @(posedge aclk) begin
        if (!arst_n) begin
            state_q    <= ST_IDLE;
            tick_div_q <= '0;
            hold_len_q <= '0;
            cnt_q      <= '0;
            hold_q     <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            tdata_q    <= '0;
            tvalid_q   <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            tick_div_q <= tick_div_d;
            hold_len_q <= hold_len_d;
            cnt_q      <= cnt_d;
            hold_q     <= hold_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            tdata_q    <= tdata_d;
            tvalid_q   <= tvalid_d;
            underrun_q <= underrun_d;
        end
    end

    always_ff @(posedge aclk) begin
        mem_q <= mem_d;
    end

`ifdef DSM_SCHED_UNDERRUN_CNT_EN
    logic [15:0] urun_cnt_q, urun_cnt_d;

    always_comb begin
        urun_cnt_d = urun_cnt_q;
        if (state_q == ST_IDLE && state_d == ST_PRIME) begin
            urun_cnt_d = '0;
        end else if (underrun_d && urun_cnt_q != '1) begin
            urun_cnt_d = urun_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge aclk) begin
        if (!arst_n) begin
            urun_cnt_q <= '0;
        end else begin
            urun_cnt_q <= urun_cnt_d;
        end
    end

    assign underrun_count = urun_cnt_q;
`else
    assign underrun_count = '0;
`endif

endmodule

// File: tb/tb_dsm_rate_scheduler.sv
// Self-checking bench for dsm_rate_scheduler: vector table, hand-built corner sequences,
// and randomized traffic checked against a beat-stream model of the hold/underrun rules.
module tb_dsm_rate_scheduler;

    logic        aclk = 1'b0;
    logic        arst_n = 1'b0;
    logic        enable = 1'b0;
    logic [7:0]  tick_div = '0;
    logic [7:0]  hold_len = '0;
    logic [15:0] s_axis_data_tdata = '0;
    logic        s_axis_data_tvalid = 1'b0;
    logic        s_axis_data_tready;
    logic [15:0] m_axis_data_tdata;
    logic        m_axis_data_tvalid;
    logic        m_axis_data_tready = 1'b1;
    logic [1:0]  state;
    logic        underrun;
    logic [15:0] underrun_count;

    dsm_rate_scheduler #(
        .WIDTH      (16),
        .DIV_W      (8),
        .FIFO_DEPTH (4),
        .PRIME_LEVEL(2)
    ) dut (
        .aclk              (aclk),
        .arst_n            (arst_n),
        .enable            (enable),
        .tick_div          (tick_div),
        .hold_len          (hold_len),
        .s_axis_data_tdata (s_axis_data_tdata),
        .s_axis_data_tvalid(s_axis_data_tvalid),
        .s_axis_data_tready(s_axis_data_tready),
        .m_axis_data_tdata (m_axis_data_tdata),
        .m_axis_data_tvalid(m_axis_data_tvalid),
        .m_axis_data_tready(m_axis_data_tready),
        .state             (state),
        .underrun          (underrun),
        .underrun_count    (underrun_count)
    );

    always #5 aclk = ~aclk;

`ifdef DSM_SCHED_UNDERRUN_CNT_EN
    localparam int unsigned EXP_URUN3 = 3;
`else
    localparam int unsigned EXP_URUN3 = 0;
`endif

    int          n_cmp = 0;
    int          n_err = 0;
    int          cyc = 0;
    int          ur_cnt = 0;
    bit          ur_pend = 1'b0;
    bit          last_push = 1'b0;
    bit          chk_stall = 1'b0;
    bit          prev_stall = 1'b0;
    logic [15:0] prev_data = '0;
    logic [15:0] beat_d[$];
    int          beat_c[$];
    bit          beat_u[$];
    logic [15:0] pushed[$];

    typedef struct {
        logic [7:0]  td;
        logic [7:0]  hl;
        logic [15:0] s0, s1, s2;
        int unsigned rep;
        int unsigned gap;
    } vec_t;
    vec_t vecs[4];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h required %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic fail_to(input string name);
        n_cmp++;
        n_err++;
        $display("FAIL %s: got timeout required event (t=%0t)", name, $time);
    endtask

    always @(posedge aclk) cyc <= cyc + 1;

    // Beat/push monitor, sampled mid-cycle.
    always @(negedge aclk) begin
        if (underrun) begin
            ur_cnt++;
            ur_pend = 1'b1;
        end
        if (m_axis_data_tvalid && m_axis_data_tready) begin
            beat_d.push_back(m_axis_data_tdata);
            beat_c.push_back(cyc);
            beat_u.push_back(ur_pend);
            ur_pend = 1'b0;
        end
        last_push = s_axis_data_tvalid && s_axis_data_tready;
        if (last_push) pushed.push_back(s_axis_data_tdata);
        if (chk_stall && prev_stall) begin
            chk("stall_tvalid", 32'(m_axis_data_tvalid), 32'd1);
            chk("stall_tdata", 32'(m_axis_data_tdata), 32'(prev_data));
        end
        prev_stall = chk_stall && m_axis_data_tvalid && !m_axis_data_tready;
        prev_data  = m_axis_data_tdata;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1, "watchdog");
    end

    task automatic step(input int n);
        repeat (n) @(posedge aclk);
        #1;
    endtask

    task automatic mon_clear();
        beat_d.delete();
        beat_c.delete();
        beat_u.delete();
        pushed.delete();
        ur_pend = 1'b0;
    endtask

    task automatic do_reset();
        enable = 1'b0;
        s_axis_data_tvalid = 1'b0;
        m_axis_data_tready = 1'b1;
        arst_n = 1'b0;
        step(2);
        arst_n = 1'b1;
        mon_clear();
    endtask

    task automatic push(input logic [15:0] v);
        int k = 0;
        s_axis_data_tdata  = v;
        s_axis_data_tvalid = 1'b1;
        while (!s_axis_data_tready && k < 500) begin
            step(1);
            k++;
        end
        if (!s_axis_data_tready) fail_to("push_ready");
        step(1);
        s_axis_data_tvalid = 1'b0;
    endtask

    task automatic wait_ur(input int base, input int budget, input string name);
        int k = 0;
        while (ur_cnt == base && k < budget) begin
            step(1);
            k++;
        end
        if (ur_cnt == base) fail_to(name);
    endtask

    function automatic int first_nz();
        for (int i = 0; i < beat_d.size(); i++)
            if (beat_d[i] != 16'h0) return i;
        return -1;
    endfunction

    initial begin
        int          c0, f, n, k, u0, idx;
        logic [15:0] sv[3];
        logic [15:0] expd, d, held;
        bit          prev_nz;

        vecs[0] = '{td: 8'd1, hl: 8'd2, s0: 16'd100,   s1: 16'd200,   s2: 16'd300,   rep: 3, gap: 2};
        vecs[1] = '{td: 8'd0, hl: 8'd0, s0: 16'h8000,  s1: 16'h7FFF,  s2: 16'hFFFF,  rep: 1, gap: 1};
        vecs[2] = '{td: 8'd3, hl: 8'd1, s0: 16'd5,     s1: 16'hFFFB,  s2: 16'd42,    rep: 2, gap: 4};
        vecs[3] = '{td: 8'd0, hl: 8'd3, s0: 16'd1,     s1: 16'd2,     s2: 16'd3,     rep: 4, gap: 1};

        // Reset state and PRIME cadence of zero beats.
        do_reset();
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_tvalid", 32'(m_axis_data_tvalid), 32'd0);
        chk("rst_tdata", 32'(m_axis_data_tdata), 32'd0);
        chk("rst_underrun", 32'(underrun), 32'd0);
        chk("rst_ucount", 32'(underrun_count), 32'd0);
        chk("rst_sready", 32'(s_axis_data_tready), 32'd0);
        tick_div = 8'd3;
        enable = 1'b1;
        c0 = cyc;
        step(1);
        chk("en_state", 32'(state), 32'd1);
        chk("en_sready", 32'(s_axis_data_tready), 32'd1);
        u0 = ur_cnt;
        step(20);
        if (beat_d.size() < 4) fail_to("prime_beats");
        else begin
            chk("prime_first_lat", 32'(beat_c[0] - c0), 32'd5);
            for (int i = 0; i < 4; i++) begin
                chk($sformatf("prime_data%0d", i), 32'(beat_d[i]), 32'd0);
                if (i > 0) chk($sformatf("prime_gap%0d", i), 32'(beat_c[i] - beat_c[i-1]), 32'd4);
            end
        end
        chk("prime_no_underrun", 32'(ur_cnt - u0), 32'd0);

        // Vector table: prime, hold, cadence, underrun, re-prime.
        for (int v = 0; v < 4; v++) begin
            do_reset();
            tick_div = vecs[v].td;
            hold_len = vecs[v].hl;
            enable = 1'b1;
            step(1);
            sv[0] = vecs[v].s0; sv[1] = vecs[v].s1; sv[2] = vecs[v].s2;
            u0 = ur_cnt;
            push(sv[0]); push(sv[1]); push(sv[2]);
            wait_ur(u0, 600, $sformatf("v%0d_underrun", v));
            step(2);
            f = first_nz();
            n = 3 * int'(vecs[v].rep);
            if (f < 0 || beat_d.size() < f + n + 1) fail_to($sformatf("v%0d_beats", v));
            else begin
                for (int i = 0; i <= n; i++) begin
                    expd = (i == n) ? 16'h0 : sv[i / int'(vecs[v].rep)];
                    chk($sformatf("v%0d_data%0d", v, i), 32'(beat_d[f+i]), 32'(expd));
                    chk($sformatf("v%0d_urflag%0d", v, i), 32'(beat_u[f+i]), 32'(i == n));
                    if (i > 0)
                        chk($sformatf("v%0d_gap%0d", v, i), 32'(beat_c[f+i] - beat_c[f+i-1]), 32'(vecs[v].gap));
                end
            end
            chk($sformatf("v%0d_urun_pulses", v), 32'(ur_cnt - u0), 32'd1);
            chk($sformatf("v%0d_state_prime", v), 32'(state), 32'd1);
            push(sv[0]); push(sv[1]);
            k = 0;
            while (state != 2'd2 && k < 100) begin step(1); k++; end
            chk($sformatf("v%0d_reprime_run", v), 32'(state), 32'd2);
        end

        // Backpressure mid-RUN plus ignored config change.
        do_reset();
        tick_div = 8'd1;
        hold_len = 8'd1;
        enable = 1'b1;
        step(1);
        u0 = ur_cnt;
        push(16'd10); push(16'd20); push(16'd30); push(16'd40);
        k = 0;
        while (!(m_axis_data_tvalid && m_axis_data_tdata == 16'd10) && k < 100) begin step(1); k++; end
        if (k == 100) fail_to("bp_first_beat");
        tick_div = 8'd7;
        hold_len = 8'd5;
        m_axis_data_tready = 1'b0;
        held = m_axis_data_tdata;
        for (int i = 0; i < 5; i++) begin
            step(1);
            chk("bp_hold_tvalid", 32'(m_axis_data_tvalid), 32'd1);
            chk("bp_hold_tdata", 32'(m_axis_data_tdata), 32'(held));
        end
        chk("bp_state_run", 32'(state), 32'd2);
        m_axis_data_tready = 1'b1;
        wait_ur(u0, 200, "bp_underrun");
        step(2);
        f = first_nz();
        if (f < 0 || beat_d.size() < f + 9) fail_to("bp_beats");
        else begin
            sv[0] = 16'd0;
            for (int i = 0; i < 9; i++) begin
                expd = (i == 8) ? 16'h0 : 16'(10 * (i / 2 + 1));
                chk($sformatf("bp_data%0d", i), 32'(beat_d[f+i]), 32'(expd));
                if (i == 1) chk("bp_release_gap", 32'(beat_c[f+1] - beat_c[f]), 32'd1);
                if (i >= 2) chk($sformatf("bp_gap%0d", i), 32'(beat_c[f+i] - beat_c[f+i-1]), 32'd2);
            end
        end

        // Full FIFO, disable flush, abandoned beat.
        do_reset();
        tick_div = 8'd200;
        hold_len = 8'd0;
        enable = 1'b1;
        step(1);
        push(16'd1); push(16'd2); push(16'd3); push(16'd4);
        chk("full_sready", 32'(s_axis_data_tready), 32'd0);
        chk("full_no_tick", 32'(m_axis_data_tvalid), 32'd0);
        tick_div = 8'd0;
        enable = 1'b0;
        step(1);
        chk("dis_state", 32'(state), 32'd0);
        chk("dis_tvalid", 32'(m_axis_data_tvalid), 32'd0);
        chk("dis_sready", 32'(s_axis_data_tready), 32'd0);
        enable = 1'b1;
        step(1);
        mon_clear();
        step(10);
        chk("flush_state_prime", 32'(state), 32'd1);
        chk("flush_first_nz", 32'(first_nz()), 32'hFFFF_FFFF);
        chk("flush_zero_beats", 32'(beat_d.size() >= 8), 32'd1);
        m_axis_data_tready = 1'b0;
        step(2);
        chk("abandon_pending", 32'(m_axis_data_tvalid), 32'd1);
        enable = 1'b0;
        step(1);
        chk("abandon_tvalid", 32'(m_axis_data_tvalid), 32'd0);
        chk("abandon_state", 32'(state), 32'd0);
        m_axis_data_tready = 1'b1;

        // Underrun counter.
        do_reset();
        tick_div = 8'd0;
        hold_len = 8'd0;
        enable = 1'b1;
        step(1);
        u0 = ur_cnt;
        for (int r = 0; r < 3; r++) begin
            push(16'h0AA0); push(16'h0BB0);
            wait_ur(u0 + r, 100, $sformatf("cnt_underrun%0d", r));
        end
        step(2);
        chk("cnt_pulses", 32'(ur_cnt - u0), 32'd3);
        chk("cnt_value", 32'(underrun_count), 32'(EXP_URUN3));
        enable = 1'b0;
        step(1);
        chk("cnt_idle_hold", 32'(underrun_count), 32'(EXP_URUN3));
        enable = 1'b1;
        step(1);
        chk("cnt_cleared", 32'(underrun_count), 32'd0);

        // Randomized traffic against a beat-stream model.
        for (int cfg = 0; cfg < 3; cfg++) begin
            do_reset();
            tick_div = 8'($urandom_range(0, 3));
            hold_len = 8'($urandom_range(0, 3));
            enable = 1'b1;
            step(1);
            mon_clear();
            chk_stall = 1'b1;
            for (int c = 0; c < 1500; c++) begin
                if (!s_axis_data_tvalid || last_push) begin
                    s_axis_data_tvalid = ($urandom_range(0, 2) == 0);
                    d = 16'($urandom);
                    if (d == 16'h0) d = 16'h1;
                    s_axis_data_tdata = d;
                end
                m_axis_data_tready = ($urandom_range(0, 4) != 0);
                step(1);
            end
            s_axis_data_tvalid = 1'b0;
            m_axis_data_tready = 1'b1;
            step(1);
            chk_stall = 1'b0;
            step(1);
            // Output = pushed samples in order, each repeated hold_len+1 times; zeros only at
            // group boundaries, and the first zero after a sample is the underrun beat.
            idx = 0;
            k = 0;
            prev_nz = 1'b0;
            chk($sformatf("rnd%0d_has_beats", cfg), 32'(beat_d.size() > 100), 32'd1);
            for (int i = 0; i < beat_d.size(); i++) begin
                if (beat_d[i] == 16'h0) begin
                    chk("rnd_zero_boundary", 32'(k), 32'd0);
                    chk("rnd_urflag_zero", 32'(beat_u[i]), 32'(prev_nz));
                    prev_nz = 1'b0;
                end else begin
                    if (idx >= pushed.size()) fail_to("rnd_extra_beat");
                    else chk("rnd_data", 32'(beat_d[i]), 32'(pushed[idx]));
                    chk("rnd_urflag_data", 32'(beat_u[i]), 32'd0);
                    k++;
                    if (k == int'(hold_len) + 1) begin
                        k = 0;
                        idx++;
                    end
                    prev_nz = 1'b1;
                end
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
